// File: rtl/lfsr_gen_pkg.sv
// Shared types and default constants for the lfsr_gen family.
package lfsr_gen_pkg;

    typedef enum logic {
        LFSR_FIBONACCI = 1'b0,
        LFSR_GALOIS    = 1'b1
    } lfsr_mode_e;

    // Maximal-length tap masks; bit k is the coefficient of x^(k+1).
    localparam logic [3:0]  LFSR4_POLY  = 4'b1100;        // 1 + x^3 + x^4
    localparam logic [3:0]  LFSR4_SEED  = 4'b1011;
    localparam logic [7:0]  LFSR8_POLY  = 8'hB8;          // 1 + x^4 + x^5 + x^6 + x^8
    localparam logic [7:0]  LFSR8_SEED  = 8'h01;
    localparam logic [15:0] LFSR16_POLY = 16'hB400;       // 1 + x^11 + x^13 + x^14 + x^16
    localparam logic [15:0] LFSR16_SEED = 16'hACE1;
    localparam logic [31:0] LFSR32_POLY = 32'h8020_0003;  // 1 + x + x^2 + x^22 + x^32
    localparam logic [31:0] LFSR32_SEED = 32'h0000_0001;

    // Default tap mask for the supported standard lengths (0 when none is tabulated).
    function automatic logic [63:0] lfsr_default_poly(input int n);
        case (n)
            4:       return 64'(LFSR4_POLY);
            8:       return 64'(LFSR8_POLY);
            16:      return 64'(LFSR16_POLY);
            32:      return 64'(LFSR32_POLY);
            default: return 64'd0;
        endcase
    endfunction

    // Default seed for the supported standard lengths (1 otherwise, never zero).
    function automatic logic [63:0] lfsr_default_seed(input int n);
        case (n)
            4:       return 64'(LFSR4_SEED);
            8:       return 64'(LFSR8_SEED);
            16:      return 64'(LFSR16_SEED);
            32:      return 64'(LFSR32_SEED);
            default: return 64'd1;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_gen_if.sv
// Valid/ready output channel carrying one generated word per transfer.
interface lfsr_gen_if #(
    parameter int OUT_WIDTH = 1
) ();
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/lfsr_gen_step.sv
// One combinational LFSR step in either Fibonacci or Galois form.
module lfsr_gen_step
    import lfsr_gen_pkg::*;
#(
    parameter int         N    = 4,
    parameter logic [N-1:0] POLY = '1,
    parameter lfsr_mode_e MODE = LFSR_FIBONACCI
) (
    input  logic [N-1:0] state_i,
    output logic [N-1:0] state_o,
    output logic         bit_o
);

    // The emitted bit is always the MSB before the shift; only the feedback differs.
    always_comb begin
        bit_o = state_i[N-1];
        if (MODE == LFSR_GALOIS) begin
            state_o = {state_i[N-2:0], 1'b0} ^ (state_i[N-1] ? {POLY[N-2:0], 1'b1} : '0);
        end else begin
            state_o = {state_i[N-2:0], ^(state_i & POLY)};
        end
    end

endmodule

// File: rtl/lfsr_gen.sv
// Multi-bit LFSR pattern source with seed load, lock-up recovery and
// period-wrap detection, delivering words over a valid/ready register.
module lfsr_gen
    import lfsr_gen_pkg::*;
#(
    parameter int                     LFSR_LENGTH    = 4,
    parameter logic [LFSR_LENGTH-1:0] LFSR_PRIM_POLY = LFSR4_POLY,
    parameter logic [LFSR_LENGTH-1:0] LFSR_SEED_VAL  = LFSR4_SEED,
    parameter lfsr_mode_e             LFSR_MODE      = LFSR_FIBONACCI,
    parameter int                     OUT_WIDTH      = 1
) (
    input  logic                   lfsr_clk,
    input  logic                   reset,
    input  logic                   lfsr_en,
    input  logic                   seed_load,
    input  logic [LFSR_LENGTH-1:0] seed_val,
    lfsr_gen_if.master             out_if,
    output logic [LFSR_LENGTH-1:0] lfsr_state_out,
    output logic                   period_wrap,
    output logic                   lockup_err
);

    localparam int N = LFSR_LENGTH;

    logic [N-1:0]         state_q, state_d;
    logic [N-1:0]         seed_q, seed_d;
    logic                 valid_q, valid_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic                 wrap_q, wrap_d;
    logic                 lockup_q, lockup_d;

    logic [OUT_WIDTH-1:0] bits_w;
    logic [OUT_WIDTH-1:0] hit_w;
    logic [N-1:0]         last_w;
    logic                 adv_w;

    // Chain of OUT_WIDTH steps; step j's bit lands at out_data[OUT_WIDTH-1-j].
    for (genvar j = 0; j < OUT_WIDTH; j++) begin : g_step
        logic [N-1:0] cur;
        logic [N-1:0] nxt;

        if (j == 0) begin : g_first
            assign cur = state_q;
        end else begin : g_next
            assign cur = g_step[j-1].nxt;
        end

        lfsr_gen_step #(
            .N    (N),
            .POLY (LFSR_PRIM_POLY),
            .MODE (LFSR_MODE)
        ) u_step (
            .state_i (cur),
            .state_o (nxt),
            .bit_o   (bits_w[OUT_WIDTH-1-j])
        );

        assign hit_w[j] = (nxt == seed_q);
    end

    assign last_w = g_step[OUT_WIDTH-1].nxt;

    // A new word may be produced when the output register is empty or being drained.
    assign adv_w = lfsr_en & ~seed_load & (~valid_q | out_if.out_ready);

    // Next-state selection: seed load beats advance; a drained register with no advance empties.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        valid_d  = valid_q;
        data_d   = data_q;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (seed_load) begin
            valid_d = 1'b0;
            data_d  = '0;
            if (seed_val != '0) begin
                state_d = seed_val;
                seed_d  = seed_val;
            end else begin
                state_d  = LFSR_SEED_VAL;
                seed_d   = LFSR_SEED_VAL;
                lockup_d = 1'b1;
            end
        end else if (adv_w) begin
            state_d = last_w;
            data_d  = bits_w;
            valid_d = 1'b1;
            wrap_d  = |hit_w;
        end else if (out_if.out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset to the default seed.
    always_ff @(posedge lfsr_clk) begin
        if (reset) begin
            state_q  <= LFSR_SEED_VAL;
            seed_q   <= LFSR_SEED_VAL;
            valid_q  <= 1'b0;
            data_q   <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign lfsr_state_out   = state_q;
    assign period_wrap      = wrap_q;
    assign lockup_err       = lockup_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Bench for lfsr_gen: three instances (Fibonacci x1, Galois x1, Fibonacci x4)
// driven by shared stimulus and checked against a polynomial-arithmetic model.
module tb_lfsr_gen;
    import lfsr_gen_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic       sl;
    logic [3:0] sv;
    logic       rdy;

    int n_tests;
    int n_fail;

    lfsr_gen_if #(.OUT_WIDTH(1)) if_f ();
    lfsr_gen_if #(.OUT_WIDTH(1)) if_g ();
    lfsr_gen_if #(.OUT_WIDTH(4)) if_w ();

    assign if_f.out_ready = rdy;
    assign if_g.out_ready = rdy;
    assign if_w.out_ready = rdy;

    logic [3:0] st0, st1, st2;
    logic       wr0, wr1, wr2;
    logic       lk0, lk1, lk2;

    lfsr_gen #(.LFSR_LENGTH(4), .LFSR_PRIM_POLY(4'b1100), .LFSR_SEED_VAL(4'b1011),
               .LFSR_MODE(LFSR_FIBONACCI), .OUT_WIDTH(1)) dut_f (
        .lfsr_clk(clk), .reset(rst), .lfsr_en(en), .seed_load(sl), .seed_val(sv),
        .out_if(if_f.master), .lfsr_state_out(st0), .period_wrap(wr0), .lockup_err(lk0));

    lfsr_gen #(.LFSR_LENGTH(4), .LFSR_PRIM_POLY(4'b1100), .LFSR_SEED_VAL(4'b1011),
               .LFSR_MODE(LFSR_GALOIS), .OUT_WIDTH(1)) dut_g (
        .lfsr_clk(clk), .reset(rst), .lfsr_en(en), .seed_load(sl), .seed_val(sv),
        .out_if(if_g.master), .lfsr_state_out(st1), .period_wrap(wr1), .lockup_err(lk1));

    lfsr_gen #(.LFSR_LENGTH(4), .LFSR_PRIM_POLY(4'b1100), .LFSR_SEED_VAL(4'b1011),
               .LFSR_MODE(LFSR_FIBONACCI), .OUT_WIDTH(4)) dut_w (
        .lfsr_clk(clk), .reset(rst), .lfsr_en(en), .seed_load(sl), .seed_val(sv),
        .out_if(if_w.master), .lfsr_state_out(st2), .period_wrap(wr2), .lockup_err(lk2));

    // Observed outputs gathered per lane: 0 = Fibonacci x1, 1 = Galois x1, 2 = Fibonacci x4.
    logic [3:0] d_state [3];
    logic [3:0] d_data  [3];
    logic       d_valid [3];
    logic       d_wrap  [3];
    logic       d_lock  [3];

    assign d_state[0] = st0;
    assign d_state[1] = st1;
    assign d_state[2] = st2;
    assign d_data[0]  = {3'b000, if_f.out_data};
    assign d_data[1]  = {3'b000, if_g.out_data};
    assign d_data[2]  = if_w.out_data;
    assign d_valid[0] = if_f.out_valid;
    assign d_valid[1] = if_g.out_valid;
    assign d_valid[2] = if_w.out_valid;
    assign d_wrap[0]  = wr0;
    assign d_wrap[1]  = wr1;
    assign d_wrap[2]  = wr2;
    assign d_lock[0]  = lk0;
    assign d_lock[1]  = lk1;
    assign d_lock[2]  = lk2;

    // Reference model state.
    logic [3:0] m_state [3];
    logic [3:0] m_seed  [3];
    logic [3:0] m_data  [3];
    logic       m_valid [3];
    logic       m_wrap  [3];
    logic       m_lock  [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Galois: multiply by x modulo P(x) = x^4 + x^3 + 1 (25).
    // Fibonacci: shift in the parity of the tapped bits x^3, x^4.
    function automatic logic [3:0] mstep(input logic [3:0] s, input bit gal);
        int v;
        if (gal) begin
            v = int'(s) * 2;
            if (v >= 16) v = v ^ 25;
            return v[3:0];
        end
        return {s[2:0], ($countones(s & 4'b1100) % 2) == 1};
    endfunction

    task automatic cycle();
        logic [3:0] ns [3];
        logic [3:0] nseed [3];
        logic [3:0] nd [3];
        logic       nv [3];
        logic       nw [3];
        logic       nl [3];
        logic [3:0] s;
        logic [3:0] word;
        int         w;
        for (int l = 0; l < 3; l++) begin
            ns[l] = m_state[l]; nseed[l] = m_seed[l]; nd[l] = m_data[l];
            nv[l] = m_valid[l]; nw[l] = 1'b0; nl[l] = 1'b0;
            w = (l == 2) ? 4 : 1;
            if (rst) begin
                ns[l] = 4'b1011; nseed[l] = 4'b1011; nd[l] = 4'b0; nv[l] = 1'b0;
            end else if (sl) begin
                nv[l] = 1'b0; nd[l] = 4'b0;
                if (sv != 4'b0) begin
                    ns[l] = sv; nseed[l] = sv;
                end else begin
                    ns[l] = 4'b1011; nseed[l] = 4'b1011; nl[l] = 1'b1;
                end
            end else if (en && (!m_valid[l] || rdy)) begin
                s = m_state[l];
                word = 4'b0;
                for (int j = 0; j < w; j++) begin
                    word = {word[2:0], s[3]};
                    s = mstep(s, l == 1);
                    if (s == m_seed[l]) nw[l] = 1'b1;
                end
                ns[l] = s; nd[l] = word; nv[l] = 1'b1;
            end else if (rdy) begin
                nv[l] = 1'b0;
            end
        end
        @(posedge clk);
        for (int l = 0; l < 3; l++) begin
            m_state[l] = ns[l]; m_seed[l] = nseed[l]; m_data[l] = nd[l];
            m_valid[l] = nv[l]; m_wrap[l] = nw[l]; m_lock[l] = nl[l];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; sl = 1'b0; sv = 4'b0; rdy = 1'b1;
        cycle();
        cycle();
        for (int l = 0; l < 3; l++) begin
            n_tests++;
            if ({d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]} !== 11'b0_0000_1011_0_0) begin
                n_fail++;
                $display("FAIL reset lane%0d: got %b expected %b", l,
                         {d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]}, 11'b0_0000_1011_0_0);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_fib_seq();
        logic [3:0] exp_st [3] = '{4'b0111, 4'b1111, 4'b1110};
        logic       exp_d  [3] = '{1'b1, 1'b0, 1'b1};
        en = 1'b1; rdy = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycle();
            if (k <= 3) begin
                n_tests++;
                if (st0 !== exp_st[k-1] || if_f.out_data !== exp_d[k-1] || if_f.out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL fib_seq adv%0d: got s=%b d=%b v=%b expected s=%b d=%b v=1",
                             k, st0, if_f.out_data, if_f.out_valid, exp_st[k-1], exp_d[k-1]);
                end
            end
            n_tests++;
            if (wr0 !== (k == 15)) begin
                n_fail++;
                $display("FAIL fib_wrap adv%0d: got %b expected %b", k, wr0, k == 15);
            end
            for (int l = 0; l < 3; l++) begin
                n_tests++;
                if ({d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]} !==
                    {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]}) begin
                    n_fail++;
                    $display("FAIL fib_model lane%0d: got %b expected %b", l,
                             {d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]},
                             {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]});
                end
            end
        end
    endtask

    task automatic test_galois_period();
        logic [3:0] exp_st [3] = '{4'b1111, 4'b0111, 4'b1110};
        rst = 1'b1; cycle(); rst = 1'b0;
        en = 1'b1; rdy = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (k <= 3) begin
                n_tests++;
                if (st1 !== exp_st[k-1]) begin
                    n_fail++;
                    $display("FAIL galois_seq adv%0d: got %b expected %b", k, st1, exp_st[k-1]);
                end
            end
            n_tests++;
            if (wr1 !== (k % 15 == 0)) begin
                n_fail++;
                $display("FAIL galois_wrap adv%0d: got %b expected %b", k, wr1, k % 15 == 0);
            end
            for (int l = 0; l < 3; l++) begin
                n_tests++;
                if ({d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]} !==
                    {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]}) begin
                    n_fail++;
                    $display("FAIL galois_model lane%0d: got %b expected %b", l,
                             {d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]},
                             {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]});
                end
            end
        end
    endtask

    task automatic test_wide_word();
        logic [3:0] exp_d  [2] = '{4'b1011, 4'b1100};
        logic [3:0] exp_st [2] = '{4'b1100, 4'b0100};
        rst = 1'b1; cycle(); rst = 1'b0;
        en = 1'b1; rdy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_tests++;
            if (if_w.out_data !== exp_d[k] || st2 !== exp_st[k] || if_w.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL wide_word adv%0d: got d=%b s=%b v=%b expected d=%b s=%b v=1",
                         k + 1, if_w.out_data, st2, if_w.out_valid, exp_d[k], exp_st[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1; cycle(); rst = 1'b0;
        en = 1'b1; rdy = 1'b1;
        cycle(); cycle();
        rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            n_tests++;
            if (st0 !== 4'b1111 || if_f.out_data !== 1'b0 || if_f.out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL backpressure hold%0d: got s=%b d=%b v=%b expected s=1111 d=0 v=1",
                         k, st0, if_f.out_data, if_f.out_valid);
            end
            for (int l = 0; l < 3; l++) begin
                n_tests++;
                if ({d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]} !==
                    {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]}) begin
                    n_fail++;
                    $display("FAIL bp_model lane%0d: got %b expected %b", l,
                             {d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]},
                             {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]});
                end
            end
        end
        rdy = 1'b1;
        cycle();
        n_tests++;
        if (st0 !== 4'b1110 || if_f.out_data !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release1: got s=%b d=%b expected s=1110 d=1", st0, if_f.out_data);
        end
        cycle();
        n_tests++;
        if (st0 !== 4'b1100 || if_f.out_data !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release2: got s=%b d=%b expected s=1100 d=1", st0, if_f.out_data);
        end
    endtask

    task automatic test_seed_load();
        en = 1'b1; rdy = 1'b1; sl = 1'b1; sv = 4'b0001;
        cycle();
        n_tests++;
        if (st0 !== 4'b0001 || if_f.out_valid !== 1'b0 || if_f.out_data !== 1'b0 || lk0 !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_load: got s=%b v=%b d=%b lk=%b expected s=0001 v=0 d=0 lk=0",
                     st0, if_f.out_valid, if_f.out_data, lk0);
        end
        sv = 4'b0000;
        cycle();
        n_tests++;
        if (st0 !== 4'b1011 || st2 !== 4'b1011 || lk0 !== 1'b1 || lk2 !== 1'b1 || if_f.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_zero: got s=%b/%b lk=%b/%b v=%b expected s=1011/1011 lk=1/1 v=0",
                     st0, st2, lk0, lk2, if_f.out_valid);
        end
        sl = 1'b0; en = 1'b0;
        cycle();
        n_tests++;
        if (lk0 !== 1'b0 || st0 !== 4'b1011) begin
            n_fail++;
            $display("FAIL lockup_pulse: got lk=%b s=%b expected lk=0 s=1011", lk0, st0);
        end
    endtask

    task automatic test_reset_with_load();
        en = 1'b1; rdy = 1'b1; sl = 1'b0;
        cycle(); cycle(); cycle();
        rst = 1'b1; sl = 1'b1; sv = 4'b0000;
        cycle();
        for (int l = 0; l < 3; l++) begin
            n_tests++;
            if ({d_valid[l], d_state[l], d_lock[l], d_wrap[l]} !== 7'b0_1011_0_0) begin
                n_fail++;
                $display("FAIL reset_load lane%0d: got %b expected %b", l,
                         {d_valid[l], d_state[l], d_lock[l], d_wrap[l]}, 7'b0_1011_0_0);
            end
        end
        rst = 1'b0; sl = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            sl  = ($urandom_range(0, 15) == 0);
            sv  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
            en  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            cycle();
            for (int l = 0; l < 3; l++) begin
                n_tests++;
                if ({d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]} !==
                    {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]}) begin
                    n_fail++;
                    $display("FAIL random cyc%0d lane%0d: got %b expected %b", k, l,
                             {d_valid[l], d_data[l], d_state[l], d_wrap[l], d_lock[l]},
                             {m_valid[l], m_data[l], m_state[l], m_wrap[l], m_lock[l]});
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int l = 0; l < 3; l++) begin
            m_state[l] = 4'b1011; m_seed[l] = 4'b1011; m_data[l] = 4'b0;
            m_valid[l] = 1'b0; m_wrap[l] = 1'b0; m_lock[l] = 1'b0;
        end
        test_reset();
        test_fib_seq();
        test_galois_period();
        test_wide_word();
        test_backpressure();
        test_seed_load();
        test_reset_with_load();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
